// File: rtl/mac_array.sv
// ----------------------------------------------------------------------------
// mac_array
//
// Purpose:
//   Array of `col` signed multiply-accumulate columns. Each column stores one
//   pr-lane signed key vector. Load instructions write key vectors into the
//   columns round-robin. An execute instruction pushes a query vector down a
//   col-deep skew chain, reaching one column per cycle. Each column produces a
//   signed dot product (key . query) on `out` together with a one-cycle
//   `fifo_wr` strobe for the output FIFO that follows it.
//
// Ports:
//   clk      in   1             single clock, rising edge
//   reset    in   1             asynchronous reset, active low (0 = reset)
//   inst     in   2             01 = load key, 10 = execute, 00/11 = idle
//   in       in   pr*bw         signed vector, lane k = in[bw*k +: bw]
//   out      out  bw_psum*col   column c psum = out[bw_psum*c +: bw_psum]
//   fifo_wr  out  col           bit c pulses for one cycle when out[c] updates
//
// Configuration:
//   MAC_ARRAY_ACCUM_EN  defined   : execute accumulates out[c] <= out[c] + dot
//                                   (wraps modulo 2^bw_psum); loading a column
//                                   clears that column's out to 0.
//                       undefined : execute overwrites out[c] with dot.
// ----------------------------------------------------------------------------
module mac_array #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+6,
    parameter int pr      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               inst,
    input  logic [pr*bw-1:0]         in,
    output logic [bw_psum*col-1:0]   out,
    output logic [col-1:0]           fifo_wr
);

    localparam int ptr_w = (col > 1) ? $clog2(col) : 1;

    typedef enum logic [1:0] {
        INST_IDLE  = 2'b00,
        INST_LOAD  = 2'b01,
        INST_EXEC  = 2'b10,
        INST_IDLE3 = 2'b11
    } inst_e;

    // Key storage and round-robin load pointer
    logic [pr*bw-1:0]          key_q [col];
    logic [pr*bw-1:0]          key_d [col];
    logic [ptr_w-1:0]          ptr_q, ptr_d;

    // Skew chain: stage c holds the query currently presented to column c
    logic [pr*bw-1:0]          qry_q [col];
    logic [pr*bw-1:0]          qry_d [col];
    logic [col-1:0]            vld_q, vld_d;

    // Registered column results and strobes
    logic signed [bw_psum-1:0] psum_q [col];
    logic signed [bw_psum-1:0] psum_d [col];
    logic [col-1:0]            wr_q, wr_d;

    inst_e inst_e_w;
    logic  load_w;
    logic  exec_w;

    assign inst_e_w = inst_e'(inst);
    assign load_w   = (inst_e_w == INST_LOAD);
    assign exec_w   = (inst_e_w == INST_EXEC);

    // Signed dot product of two pr-lane vectors, each product sign-extended
    // to bw_psum before summing. The largest magnitude (pr * 2^(2bw-2)) fits
    // in bw_psum bits, so no overflow handling is needed.
    function automatic logic signed [bw_psum-1:0] dot(
        input logic [pr*bw-1:0] a,
        input logic [pr*bw-1:0] b
    );
        logic signed [bw_psum-1:0] acc;
        logic signed [bw-1:0]      x;
        logic signed [bw-1:0]      y;
        logic signed [2*bw-1:0]    p;
        acc = '0;
        for (int k = 0; k < pr; k++) begin
            x   = a[k*bw +: bw];
            y   = b[k*bw +: bw];
            p   = x * y;
            acc = acc + {{(bw_psum-2*bw){p[2*bw-1]}}, p};
        end
        return acc;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path leaves it unassigned, which would infer a latch.
        for (int c = 0; c < col; c++) begin
            key_d[c]  = key_q[c];
            qry_d[c]  = qry_q[c];
            psum_d[c] = psum_q[c];
        end
        ptr_d = ptr_q;
        vld_d = '0;
        wr_d  = '0;

        if (load_w) begin
            key_d[ptr_q] = in;
            ptr_d        = (ptr_q == ptr_w'(col-1)) ? '0 : ptr_q + ptr_w'(1);
        end

        // Query enters stage 0 on the execute edge, then moves one column per
        // cycle regardless of the instruction on the bus.
        vld_d[0] = exec_w;
        qry_d[0] = exec_w ? in : qry_q[0];
        for (int c = 1; c < col; c++) begin
            vld_d[c] = vld_q[c-1];
            qry_d[c] = qry_q[c-1];
        end

        // A column's result lands one edge after its query arrives, using the
        // key that column holds while the query sits there.
        for (int c = 0; c < col; c++) begin
            wr_d[c] = vld_q[c];
`ifdef MAC_ARRAY_ACCUM_EN
            if (load_w && (ptr_q == ptr_w'(c)))
                psum_d[c] = '0;
            if (vld_q[c])
                psum_d[c] = psum_d[c] + dot(key_q[c], qry_q[c]);
`else
            if (vld_q[c])
                psum_d[c] = dot(key_q[c], qry_q[c]);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the key and query arrays are reset explicitly because a
            // cleared key file is part of the block's visible reset state.
            for (int c = 0; c < col; c++) begin
                key_q[c]  <= '0;
                qry_q[c]  <= '0;
                psum_q[c] <= '0;
            end
            ptr_q <= '0;
            vld_q <= '0;
            wr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            for (int c = 0; c < col; c++) begin
                key_q[c]  <= key_d[c];
                qry_q[c]  <= qry_d[c];
                psum_q[c] <= psum_d[c];
            end
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            wr_q  <= wr_d;
        end
    end

    always_comb begin
        out = '0;
        for (int c = 0; c < col; c++)
            out[c*bw_psum +: bw_psum] = psum_q[c];
    end

    assign fifo_wr = wr_q;

endmodule

// File: tb/tb_mac_array.sv
// ----------------------------------------------------------------------------
// tb_mac_array
//
// Directed bench for mac_array. Each execute pushes the hand-computed psum and
// the cycle its strobe is due into a per-column queue; a monitor pops and
// compares whenever fifo_wr[c] is high. Expected values follow the
// MAC_ARRAY_ACCUM_EN build setting.
// ----------------------------------------------------------------------------
module tb_mac_array;

    localparam int COL = 8;
    localparam int BW  = 8;
    localparam int PW  = 2*BW+6;
    localparam int PR  = 8;

    logic                clk   = 1'b0;
    logic                reset = 1'b0;
    logic [1:0]          inst  = 2'b00;
    logic [PR*BW-1:0]    in_v  = '0;
    logic [PW*COL-1:0]   out;
    logic [COL-1:0]      fifo_wr;

    always #5 clk = ~clk;

    mac_array #(.col(COL), .bw(BW), .bw_psum(PW), .pr(PR)) dut (
        .clk     (clk),
        .reset   (reset),
        .inst    (inst),
        .in      (in_v),
        .out     (out),
        .fifo_wr (fifo_wr)
    );

    typedef struct {
        logic [PW-1:0] val;
        int            due;
    } exp_t;

    exp_t sb [COL][$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] col_out(input int c);
        return out[c*PW +: PW];
    endfunction

    // Monitor: every strobe must match the oldest expectation for that column
    // and arrive on exactly the due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            for (int c = 0; c < COL; c++) begin
                if (fifo_wr[c]) begin
                    if (sb[c].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_strobe col%0d: strobe seen at cycle %0d, none expected", c, cyc);
                    end else begin
                        e = sb[c].pop_front();
                        check($sformatf("psum_col%0d", c), 64'(col_out(c)), 64'(e.val));
                        check($sformatf("strobe_cycle_col%0d", c), 64'(cyc), 64'(e.due));
                    end
                end
                if (sb[c].size() > 0 && sb[c][0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_strobe col%0d: no strobe by cycle %0d, due %0d", c, cyc, sb[c][0].due);
                    void'(sb[c].pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [1:0] i, input logic [PR*BW-1:0] v);
        @(negedge clk);
        inst = i;
        in_v = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b00, '0);
    endtask

    task automatic load(input logic [PR*BW-1:0] v);
        drive(2'b01, v);
    endtask

    // Execute edge E0 is the next posedge (cycle cyc+1); column c strobes at
    // E(c+1), i.e. cycle cyc+c+2 as seen by the monitor.
    task automatic exec(input logic [PR*BW-1:0] q, input int e [COL]);
        exp_t x;
        drive(2'b10, q);
        for (int c = 0; c < COL; c++) begin
            x.val = PW'(e[c]);
            x.due = cyc + c + 2;
            sb[c].push_back(x);
        end
    endtask

    function automatic logic [PR*BW-1:0] lanes(input logic [7:0] b);
        return {PR{b}};
    endfunction

    int all0  [COL] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int all16 [COL] = '{16, 16, 16, 16, 16, 16, 16, 16};
    int all32 [COL] = '{32, 32, 32, 32, 32, 32, 32, 32};
    int neg   [COL] = '{-1016, -1016, -1016, -1016, -1016, -1016, -1016, -1016};
    int maxv  [COL] = '{131072, 131072, 131072, 131072, 131072, 131072, 131072, 131072};
    int wrap  [COL] = '{72, 80, 24, 32, 40, 48, 56, 64};
    int e1    [COL];
    int e2    [COL];
    int e3    [COL];

    initial begin
        // 1. Reset held with load/execute on the bus
        reset = 1'b0;
        drive(2'b01, lanes(8'h11));
        drive(2'b10, lanes(8'h22));
        @(posedge clk);
        #1;
        for (int c = 0; c < COL; c++)
            check($sformatf("reset_out_col%0d", c), 64'(col_out(c)), 64'd0);
        check("reset_fifo_wr", 64'(fifo_wr), 64'd0);
        drive(2'b00, '0);
        #2 reset = 1'b1;
        exec(lanes(8'h05), all0);   // no key was written during reset
        idle(12);

        // 2. Basic
        for (int i = 0; i < COL; i++) load(lanes(8'h01));
        exec(lanes(8'h02), all16);
        idle(12);
        for (int c = 0; c < COL; c++)
            check($sformatf("hold_col%0d", c), 64'(col_out(c)), 64'h10);

        // 3. Signed extremes
        for (int i = 0; i < COL; i++) load(lanes(8'hFF));
        exec(lanes(8'h7F), neg);
        idle(12);
        for (int i = 0; i < COL; i++) load(lanes(8'h80));
        exec(lanes(8'h80), maxv);
        idle(12);

        // 4. Wrap-around: loads 9 and 10 overwrite columns 0 and 1
        for (int i = 1; i <= 10; i++) load(lanes(8'(i)));
        exec(lanes(8'h01), wrap);
        idle(12);

        // 5. Back-to-back executes, then reset while a third is in flight
        for (int c = 0; c < COL; c++) begin
`ifdef MAC_ARRAY_ACCUM_EN
            e1[c] = 2 * wrap[c];
            e2[c] = 4 * wrap[c];
            e3[c] = 5 * wrap[c];
`else
            e1[c] = wrap[c];
            e2[c] = 2 * wrap[c];
            e3[c] = wrap[c];
`endif
        end
        exec(lanes(8'h01), e1);
        exec(lanes(8'h02), e2);
        idle(12);
        exec(lanes(8'h01), e3);
        idle(2);                    // column 0 has strobed; the rest are in flight
        #2 reset = 1'b0;
        for (int c = 0; c < COL; c++) sb[c].delete();
        #1;
        for (int c = 0; c < COL; c++)
            check($sformatf("midreset_out_col%0d", c), 64'(col_out(c)), 64'd0);
        check("midreset_fifo_wr", 64'(fifo_wr), 64'd0);
        idle(2);
        #2 reset = 1'b1;
        idle(15);                   // any late strobe is flagged by the monitor

        // 6. Repeat the basic setup twice, then reload column 0
        for (int i = 0; i < COL; i++) load(lanes(8'h01));
        exec(lanes(8'h02), all16);
        idle(12);
`ifdef MAC_ARRAY_ACCUM_EN
        exec(lanes(8'h02), all32);
`else
        exec(lanes(8'h02), all16);
`endif
        idle(12);
        load(lanes(8'h03));
        idle(1);
`ifdef MAC_ARRAY_ACCUM_EN
        check("reload_clears_col0", 64'(col_out(0)), 64'd0);
        check("reload_keeps_col1", 64'(col_out(1)), 64'd32);
`else
        check("reload_keeps_col0", 64'(col_out(0)), 64'd16);
        check("reload_keeps_col1", 64'(col_out(1)), 64'd16);
`endif

        idle(20);
        for (int c = 0; c < COL; c++)
            check($sformatf("drain_col%0d", c), 64'(sb[c].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
